// File: rtl/mips_controller_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encodings,
// opcode/funct constants, ALU operation codes and the control bundle.
package mips_controller_pkg;

    localparam int unsigned OP_W      = 6;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned ALUCONT_W = 3;
    localparam int unsigned IRW_W     = 4;

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12,
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14
    } state_t;

    localparam logic [OP_W-1:0] OP_LB    = 6'b100000;
    localparam logic [OP_W-1:0] OP_SB    = 6'b101000;
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [ALUCONT_W-1:0] ALUCONT_ADD = 3'b010;
    localparam logic [ALUCONT_W-1:0] ALUCONT_SUB = 3'b110;
    localparam logic [ALUCONT_W-1:0] ALUCONT_AND = 3'b000;
    localparam logic [ALUCONT_W-1:0] ALUCONT_OR  = 3'b001;
    localparam logic [ALUCONT_W-1:0] ALUCONT_SLT = 3'b111;
    localparam logic [ALUCONT_W-1:0] ALUCONT_BAD = 3'b101;

    // Per-state control bundle; an all-zero value is the idle decode.
    typedef struct packed {
        logic             memread;
        logic             memwrite;
        logic             pcwrite;
        logic             branch;
        logic             iord;
        logic [IRW_W-1:0] irwrite;
        logic             regdst;
        logic             memtoreg;
        logic             regwrite;
        logic             alusrca;
        logic [1:0]       alusrcb;
        aluop_t           aluop;
        logic [1:0]       pcsource;
    } ctrl_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps the FSM's coarse ALU request plus the R-type funct field onto the
// datapath ALU control code.
module mips_alu_decoder
    import mips_controller_pkg::*;
(
    input  aluop_t               i_aluop,
    input  logic [FUNCT_W-1:0]   i_funct,
    output logic [ALUCONT_W-1:0] o_alucont_c
);

    always_comb begin
        o_alucont_c = ALUCONT_ADD;
        case (i_aluop)
            ALUOP_ADD: o_alucont_c = ALUCONT_ADD;
            ALUOP_SUB: o_alucont_c = ALUCONT_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FUNCT_ADD: o_alucont_c = ALUCONT_ADD;
                    FUNCT_SUB: o_alucont_c = ALUCONT_SUB;
                    FUNCT_AND: o_alucont_c = ALUCONT_AND;
                    FUNCT_OR:  o_alucont_c = ALUCONT_OR;
                    FUNCT_SLT: o_alucont_c = ALUCONT_SLT;
                    default:   o_alucont_c = ALUCONT_BAD;
                endcase
            end
            default: o_alucont_c = ALUCONT_ADD;
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// Multicycle control FSM for the 8-bit MIPS core: byte-serial fetch, decode,
// execute, memory and writeback sequencing with Moore control decodes.
module mips_controller
    import mips_controller_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OP_W-1:0]      op,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 zero,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 pcen,
    output logic                 iord,
    output logic [IRW_W-1:0]     irwrite,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [ALUCONT_W-1:0] alucont,
    output logic [1:0]           pcsource,
    output logic [STATE_W-1:0]   state
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    logic   w_run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH1;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = FETCH1;
        w_ctrl = '0;
        case (r_state)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                w_next           = (r_state == FETCH4) ? DECODE : state_t'(r_state + 4'd1);
                w_ctrl.memread   = 1'b1;
                w_ctrl.alusrcb   = 2'b01;
                w_ctrl.aluop     = ALUOP_ADD;
                w_ctrl.pcwrite   = 1'b1;
                w_ctrl.pcsource  = 2'b00;
                // Fetch state index selects which IR byte lane loads.
                w_ctrl.irwrite   = IRW_W'(1) << r_state[1:0];
            end
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: w_next = MEMADR;
                    OP_RTYPE:     w_next = RTYPEEX;
                    OP_BEQ:       w_next = BEQEX;
                    OP_J:         w_next = JEX;
                    OP_ADDI:      w_next = ADDIEX;
                    default:      w_next = FETCH1;
                endcase
                w_ctrl.alusrcb = 2'b11;
                w_ctrl.aluop   = ALUOP_ADD;
            end
            MEMADR: begin
                w_next         = (op == OP_SB) ? SBWR : LBRD;
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = 2'b10;
                w_ctrl.aluop   = ALUOP_ADD;
            end
            LBRD: begin
                w_next         = LBWR;
                w_ctrl.memread = 1'b1;
                w_ctrl.iord    = 1'b1;
            end
            LBWR: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.memtoreg = 1'b1;
            end
            SBWR: begin
                w_ctrl.memwrite = 1'b1;
                w_ctrl.iord     = 1'b1;
            end
            RTYPEEX: begin
                w_next         = RTYPEWR;
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = 2'b00;
                w_ctrl.aluop   = ALUOP_FUNCT;
            end
            RTYPEWR: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.regdst   = 1'b1;
            end
            BEQEX: begin
                w_ctrl.alusrca  = 1'b1;
                w_ctrl.aluop    = ALUOP_SUB;
                w_ctrl.branch   = 1'b1;
                w_ctrl.pcsource = 2'b01;
            end
            JEX: begin
                w_ctrl.pcwrite  = 1'b1;
                w_ctrl.pcsource = 2'b10;
            end
            ADDIEX: begin
                w_next         = ADDIWR;
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = 2'b10;
                w_ctrl.aluop   = ALUOP_ADD;
            end
            ADDIWR: begin
                w_ctrl.regwrite = 1'b1;
            end
            default: begin
                w_next = FETCH1;
            end
        endcase
    end

    mips_alu_decoder u_alu_decoder (
        .i_aluop     (w_ctrl.aluop),
        .i_funct     (funct),
        .o_alucont_c (alucont)
    );

    // State-changing strobes are suppressed for as long as reset is held.
    assign w_run    = ~reset;
    assign pcen     = w_run & (w_ctrl.pcwrite | (w_ctrl.branch & zero));
    assign regwrite = w_run & w_ctrl.regwrite;
    assign memwrite = w_run & w_ctrl.memwrite;
    assign irwrite  = w_ctrl.irwrite & {IRW_W{w_run}};

    assign memread  = w_ctrl.memread;
    assign iord     = w_ctrl.iord;
    assign regdst   = w_ctrl.regdst;
    assign memtoreg = w_ctrl.memtoreg;
    assign alusrca  = w_ctrl.alusrca;
    assign alusrcb  = w_ctrl.alusrcb;
    assign pcsource = w_ctrl.pcsource;
    assign state    = STATE_W'(r_state);

endmodule
